pc_sequencer: RTL and testbench

Program-counter owner for the five-stage pipeline. It holds the fetch PC and picks the next PC from sequential fetch, ID-stage jumps and EX-stage branch resolution. It consumes the Jump and Branch codes that the ID-stage control decoder emits and raises the flush strobes for the IF/ID and ID/EX registers. Fetch can be halted and resumed through a small state machine.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/branch_cond.sv | 23 ++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: ID jump codes, EX branch codes, PC sequencer states
// and the default reset vector.
package pipeline_pkg;

   localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0040_0000;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BNE  = 3'b010;
   localparam logic [2:0] BR_BLEZ = 3'b011;
   localparam logic [2:0] BR_BGTZ = 3'b100;
   localparam logic [2:0] BR_BLTZ = 3'b101;

   localparam logic [1:0] JMP_NONE = 2'b00;
   localparam logic [1:0] JMP_IMM  = 2'b01;
   localparam logic [1:0] JMP_REG  = 2'b10;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pcseq_state_t;

endpackage

// File: rtl/branch_cond.sv
// EX-stage branch condition evaluator. Unknown codes resolve to not-taken.
module branch_cond
   import pipeline_pkg::*;
(
   input  logic [2:0]  code,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        taken
);

   always_comb begin
      taken = 1'b0;
      case (code)
         BR_BEQ:  taken = (a == b);
         BR_BNE:  taken = (a != b);
         BR_BLEZ: taken = ($signed(a) <= 32'sd0);
         BR_BGTZ: taken = ($signed(a) >  32'sd0);
         BR_BLTZ: taken = ($signed(a) <  32'sd0);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: BOOT/RUN/HALT sequencing, branch/jump redirect and flush strobes.
// Define PC_PERF_CNT_EN to add saturating branch/jump/stall event counters.
module pc_sequencer
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
   parameter int          PC_W      = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            halt_i,
   input  logic            resume_i,
   input  logic [1:0]      id_jump_i,
   input  logic [25:0]     id_instr_idx_i,
   input  logic [PC_W-1:0] id_pc4_i,
   input  logic [PC_W-1:0] id_rs_i,
   input  logic [2:0]      ex_branch_i,
   input  logic [31:0]     ex_a_i,
   input  logic [31:0]     ex_b_i,
   input  logic [PC_W-1:0] ex_target_i,
   output logic [PC_W-1:0] pc_o,
   output logic            if_valid_o,
   output logic            if_id_flush_o,
   output logic            id_ex_flush_o,
   output logic            halted_o
`ifdef PC_PERF_CNT_EN
  ,output logic [31:0]     perf_br_taken_o,
   output logic [31:0]     perf_jump_o,
   output logic [31:0]     perf_stall_o
`endif
);

   pcseq_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            br_taken, jump_req, br_fire, jmp_fire;

   branch_cond u_branch_cond (
      .code  (ex_branch_i),
      .a     (ex_a_i),
      .b     (ex_b_i),
      .taken (br_taken)
   );

   assign jump_req = (id_jump_i == JMP_IMM) || (id_jump_i == JMP_REG);
   assign pc_o     = pc_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_valid_o    = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      halted_o      = 1'b0;
      br_fire       = 1'b0;
      jmp_fire      = 1'b0;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if_valid_o = 1'b1;
            if (br_taken) begin
               br_fire       = 1'b1;
               pc_d          = ex_target_i;
               if_id_flush_o = 1'b1;
               id_ex_flush_o = 1'b1;
            end else if (jump_req && !stall_i) begin
               jmp_fire      = 1'b1;
               if_id_flush_o = 1'b1;
               pc_d          = (id_jump_i == JMP_IMM) ?
                               {id_pc4_i[PC_W-1:PC_W-4], id_instr_idx_i, 2'b00} : id_rs_i;
            end else if (!stall_i) begin
               pc_d = pc_q + PC_W'(4);
            end
            // The halting cycle's fetch is the last one; pc parks on it and
            // resume steps past it.
            if (halt_i && !br_fire && !jmp_fire) begin
               state_d = ST_HALT;
               pc_d    = pc_q;
            end
         end
         ST_HALT: begin
            halted_o = 1'b1;
            if (resume_i && !halt_i) begin
               state_d = ST_RUN;
               pc_d    = pc_q + PC_W'(4);
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VEC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

`ifdef PC_PERF_CNT_EN
   logic [31:0] br_cnt_q, br_cnt_d, jmp_cnt_q, jmp_cnt_d, stall_cnt_q, stall_cnt_d;
   logic        stall_ev;

   assign stall_ev = (state_q == ST_RUN) && stall_i && !br_fire;

   always_comb begin
      br_cnt_d    = br_cnt_q;
      jmp_cnt_d   = jmp_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (br_fire && (br_cnt_q != 32'hFFFF_FFFF))
         br_cnt_d = br_cnt_q + 32'd1;
      if (jmp_fire && (jmp_cnt_q != 32'hFFFF_FFFF))
         jmp_cnt_d = jmp_cnt_q + 32'd1;
      if (stall_ev && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q    <= '0;
         jmp_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         br_cnt_q    <= br_cnt_d;
         jmp_cnt_q   <= jmp_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_br_taken_o = br_cnt_q;
   assign perf_jump_o     = jmp_cnt_q;
   assign perf_stall_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-cycle behavioural model compare plus directed
// literal checks of reset, branch, jump, stall, halt/resume, wrap and async reset.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_i, halt_i, resume_i;
   logic [1:0]  id_jump_i;
   logic [25:0] id_instr_idx_i;
   logic [31:0] id_pc4_i, id_rs_i;
   logic [2:0]  ex_branch_i;
   logic [31:0] ex_a_i, ex_b_i, ex_target_i;
   logic [31:0] pc_o;
   logic        if_valid_o, if_id_flush_o, id_ex_flush_o, halted_o;
`ifdef PC_PERF_CNT_EN
   logic [31:0] perf_br_taken_o, perf_jump_o, perf_stall_o;
`endif

   int errs = 0;
   int checks = 0;

   pc_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_i        (stall_i),
      .halt_i         (halt_i),
      .resume_i       (resume_i),
      .id_jump_i      (id_jump_i),
      .id_instr_idx_i (id_instr_idx_i),
      .id_pc4_i       (id_pc4_i),
      .id_rs_i        (id_rs_i),
      .ex_branch_i    (ex_branch_i),
      .ex_a_i         (ex_a_i),
      .ex_b_i         (ex_b_i),
      .ex_target_i    (ex_target_i),
      .pc_o           (pc_o),
      .if_valid_o     (if_valid_o),
      .if_id_flush_o  (if_id_flush_o),
      .id_ex_flush_o  (id_ex_flush_o),
      .halted_o       (halted_o)
`ifdef PC_PERF_CNT_EN
     ,.perf_br_taken_o (perf_br_taken_o),
      .perf_jump_o     (perf_jump_o),
      .perf_stall_o    (perf_stall_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 = boot, 1 = run, 2 = halt
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_br_cnt, m_jmp_cnt, m_stall_cnt;

   function automatic bit br_eval(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         3'd1:    return a == b;
         3'd2:    return a != b;
         3'd3:    return $signed(a) <= 0;
         3'd4:    return $signed(a) > 0;
         3'd5:    return $signed(a) < 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit jmp_ok(input logic [1:0] j, input logic st);
      return (j == 2'd1 || j == 2'd2) && !st;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode      <= 0;
         m_pc        <= 32'h0040_0000;
         m_br_cnt    <= 0;
         m_jmp_cnt   <= 0;
         m_stall_cnt <= 0;
      end else begin
         if (m_mode == 0) begin
            m_mode <= 1;
         end else if (m_mode == 1) begin
            if (br_eval(ex_branch_i, ex_a_i, ex_b_i)) begin
               m_pc <= ex_target_i;
               if (m_br_cnt != 32'hFFFF_FFFF) m_br_cnt <= m_br_cnt + 1;
            end else if (jmp_ok(id_jump_i, stall_i)) begin
               m_pc <= (id_jump_i == 2'd1) ? {id_pc4_i[31:28], id_instr_idx_i, 2'b00} : id_rs_i;
               if (m_jmp_cnt != 32'hFFFF_FFFF) m_jmp_cnt <= m_jmp_cnt + 1;
            end else if (halt_i) begin
               m_mode <= 2;
            end else if (!stall_i) begin
               m_pc <= m_pc + 32'd4;
            end
            if (stall_i && !br_eval(ex_branch_i, ex_a_i, ex_b_i) && m_stall_cnt != 32'hFFFF_FFFF)
               m_stall_cnt <= m_stall_cnt + 1;
         end else begin
            if (resume_i && !halt_i) begin
               m_mode <= 1;
               m_pc   <= m_pc + 32'd4;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit b, jo, run;
      run = (m_mode == 1);
      b   = br_eval(ex_branch_i, ex_a_i, ex_b_i);
      jo  = jmp_ok(id_jump_i, stall_i);
      chk("model pc", pc_o, m_pc);
      chk("model if_valid", 32'(if_valid_o), 32'(run));
      chk("model if_id_flush", 32'(if_id_flush_o), 32'(run && (b || jo)));
      chk("model id_ex_flush", 32'(id_ex_flush_o), 32'(run && b));
      chk("model halted", 32'(halted_o), 32'(m_mode == 2));
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      stall_i = 0; halt_i = 0; resume_i = 0;
      id_jump_i = 2'd0; id_instr_idx_i = '0; id_pc4_i = '0; id_rs_i = '0;
      ex_branch_i = 3'd0; ex_a_i = '0; ex_b_i = '0; ex_target_i = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      step();
      idle();
   endtask

   typedef struct {
      logic [2:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      bit          taken;
   } br_vec_t;

   br_vec_t vecs[9];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

   initial begin
      logic [31:0] p;
      vecs[0] = '{3'd2, 32'd5, 32'd6, 1'b1};
      vecs[1] = '{3'd2, 32'd7, 32'd7, 1'b0};
      vecs[2] = '{3'd3, 32'd0, 32'd0, 1'b1};
      vecs[3] = '{3'd3, 32'd1, 32'd0, 1'b0};
      vecs[4] = '{3'd4, 32'd0, 32'd0, 1'b0};
      vecs[5] = '{3'd4, 32'd1, 32'd0, 1'b1};
      vecs[6] = '{3'd5, 32'd0, 32'd0, 1'b0};
      vecs[7] = '{3'd6, 32'd0, 32'd0, 1'b0};
      vecs[8] = '{3'd4, 32'h8000_0000, 32'd0, 1'b0};

      idle();
      step(); step();
      chk("reset pc", pc_o, 32'h0040_0000);
      chk("reset valid", 32'(if_valid_o), 32'd0);
      chk("reset halted", 32'(halted_o), 32'd0);
      chk("reset flushes", 32'({if_id_flush_o, id_ex_flush_o}), 32'd0);

      rst_n = 1;
      #1 chk("boot pc", pc_o, 32'h0040_0000);
      chk("boot valid", 32'(if_valid_o), 32'd0);
      step();
      chk("run0 pc", pc_o, 32'h0040_0000);
      chk("run0 valid", 32'(if_valid_o), 32'd1);
      step();
      chk("run1 pc", pc_o, 32'h0040_0004);

      // beq taken
      ex_branch_i = 3'd1; ex_a_i = 5; ex_b_i = 5; ex_target_i = 32'h0040_0100;
      #1 chk("beq flushes", 32'({if_id_flush_o, id_ex_flush_o}), 32'd3);
      go();
      #1 chk("beq pc", pc_o, 32'h0040_0100);
      chk("beq flush clear", 32'({if_id_flush_o, id_ex_flush_o}), 32'd0);

      // beq not taken
      ex_branch_i = 3'd1; ex_a_i = 5; ex_b_i = 6; ex_target_i = 32'h0040_0100;
      #1 chk("beq nt flushes", 32'({if_id_flush_o, id_ex_flush_o}), 32'd0);
      go();
      #1 chk("beq nt pc", pc_o, 32'h0040_0104);

      for (int i = 0; i < 9; i++) begin
         p = pc_o;
         ex_branch_i = vecs[i].code; ex_a_i = vecs[i].a; ex_b_i = vecs[i].b;
         ex_target_i = 32'h0040_1000 + 32'(i * 16);
         #1 chk("br table flush", 32'(id_ex_flush_o), 32'(vecs[i].taken));
         go();
         #1 chk("br table pc", pc_o, vecs[i].taken ? 32'h0040_1000 + 32'(i * 16) : p + 32'd4);
      end

      // jump in ID discarded by taken bltz
      id_jump_i = 2'd1; id_instr_idx_i = 26'h40; id_pc4_i = 32'h0040_0010;
      ex_branch_i = 3'd5; ex_a_i = 32'hFFFF_FFFF; ex_target_i = 32'h0040_0200;
      #1 chk("j+bltz flushes", 32'({if_id_flush_o, id_ex_flush_o}), 32'd3);
      go();
      #1 chk("j+bltz pc", pc_o, 32'h0040_0200);

      // plain j
      id_jump_i = 2'd1; id_instr_idx_i = 26'h40; id_pc4_i = 32'h0040_0010;
      #1 chk("j flushes", 32'({if_id_flush_o, id_ex_flush_o}), 32'd2);
      go();
      #1 chk("j pc", pc_o, 32'h0000_0100);

      // jump code 11 behaves as none
      p = pc_o;
      id_jump_i = 2'd3; id_rs_i = 32'h0000_1234;
      #1 chk("jmp11 flush", 32'(if_id_flush_o), 32'd0);
      go();
      #1 chk("jmp11 pc", pc_o, p + 32'd4);

      // jr held by stall, taken on release
      p = pc_o;
      stall_i = 1; id_jump_i = 2'd2; id_rs_i = 32'h0040_0080;
      #1 chk("jr stall flush", 32'({if_id_flush_o, id_ex_flush_o}), 32'd0);
      step();
      chk("jr stall pc1", pc_o, p);
      step();
      chk("jr stall pc2", pc_o, p);
      stall_i = 0;
      #1 chk("jr release flush", 32'({if_id_flush_o, id_ex_flush_o}), 32'd2);
      go();
      #1 chk("jr pc", pc_o, 32'h0040_0080);

      // halt alongside taken bgtz: redirect first, then halt
      ex_branch_i = 3'd4; ex_a_i = 1; ex_target_i = 32'h0040_0300; halt_i = 1;
      #1 chk("halt bgtz flush", 32'(id_ex_flush_o), 32'd1);
      step();
      ex_branch_i = 3'd0;
      #1 chk("halt redirect pc", pc_o, 32'h0040_0300);
      chk("halt redirect running", 32'(halted_o), 32'd0);
      step();
      chk("halted", 32'(halted_o), 32'd1);
      chk("halted valid", 32'(if_valid_o), 32'd0);
      chk("halted pc", pc_o, 32'h0040_0300);
      resume_i = 1;
      step();
      chk("halt beats resume", 32'(halted_o), 32'd1);
      chk("halt frozen pc", pc_o, 32'h0040_0300);
      halt_i = 0;
      step();
      resume_i = 0;
      #1 chk("resumed", 32'(halted_o), 32'd0);
      chk("resumed pc", pc_o, 32'h0040_0304);
      chk("resumed valid", 32'(if_valid_o), 32'd1);
      step();
      chk("resumed pc+4", pc_o, 32'h0040_0308);

      // wrap
      id_jump_i = 2'd2; id_rs_i = 32'hFFFF_FFF8;
      go();
      #1 chk("wrap pc0", pc_o, 32'hFFFF_FFF8);
      step();
      chk("wrap pc1", pc_o, 32'hFFFF_FFFC);
      step();
      chk("wrap pc2", pc_o, 32'h0000_0000);

      // async reset mid-cycle
      step();
      #2 rst_n = 0;
      #1 chk("async rst pc", pc_o, 32'h0040_0000);
      chk("async rst valid", 32'(if_valid_o), 32'd0);
`ifdef PC_PERF_CNT_EN
      chk("perf clear", perf_br_taken_o | perf_jump_o | perf_stall_o, 32'd0);
`endif
      step();
      rst_n = 1;
      #1 chk("reboot valid", 32'(if_valid_o), 32'd0);
      step();
      chk("reboot pc", pc_o, 32'h0040_0000);
      chk("reboot valid run", 32'(if_valid_o), 32'd1);

`ifdef PC_PERF_CNT_EN
      stall_i = 1;
      step(); step();
      stall_i = 0;
      ex_branch_i = 3'd1;
      step();
      idle();
      #1 chk("perf br", perf_br_taken_o, m_br_cnt);
      chk("perf jump", perf_jump_o, m_jmp_cnt);
      chk("perf stall", perf_stall_o, 32'd2);
      chk("perf br lit", perf_br_taken_o, 32'd1);
`endif
      step(); step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
